button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end input stage that sits directly upstream of the operand-entry/ALU datapath. Takes the three raw push-buttons (increment, save, reset-inputs), synchronises and debounces each, and emits one-cycle command pulses. Also drives the button-press indicator LED. Downstream logic only ever sees clean, single-cycle, mutually exclusive commands.

## Interface

- `DEBOUNCE_CYCLES`, default 1000000: the number of consecutive stable synchronised samples required before a level change is accepted (10 ms at 100 MHz). Legal range is ≥ 2.
- `LED_HOLD_CYCLES`, default 25000000: the duration `btnPressLED` stays lit after an accepted press. Legal range is ≥ 1.
- `in_clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `incrementBtn` in 1: raw, asynchronous, bouncing button.
- `saveBtn` in 1: raw, asynchronous, bouncing button.
- `resetBtn` in 1: raw, asynchronous, bouncing button (clears operands downstream; not a block reset).
- `incrementPulse` out 1: one-cycle strobe on an accepted increment press.
- `savePulse` out 1: one-cycle strobe on an accepted save press.
- `clearPulse` out 1: one-cycle strobe on an accepted resetBtn press.
- `btnPressLED` out 1: high while the hold timer is running.

## Operation

- Each channel has a 2-flop synchroniser followed by a debounce FSM and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states:
  - **IDLE** (stable low).
  - **ARM_HI**: synced=1 seen in IDLE; counter := 1.
  - **PRESSED** (stable high).
  - **ARM_LO**: synced=0 seen in PRESSED; counter := 1.
- In ARM_HI:
  - synced=1 and counter < D: counter++.
  - synced=1 and counter == D: go to PRESSED and raise the raw press strobe.
  - synced=0: return to IDLE, counter := 0. The bounce is rejected.
- ARM_LO mirrors ARM_HI and returns to IDLE on acceptance. No strobe on release.
- The press strobe fires only on the ARM_HI→PRESSED transition. Holding a button yields exactly one pulse; there is no auto-repeat.
- Arbitration of strobes arriving in the same cycle uses fixed priority clear > save > increment.
  - Only the winner is output.
  - Losers are dropped, not queued.
  - At most one output pulse is high in any cycle.
- LED hold counter:
  - Loaded with `LED_HOLD_CYCLES` on any emitted pulse. It is retriggerable: a reload while running restarts the count.
  - Decrements to 0 otherwise.
  - `btnPressLED` = (count != 0).

## Timing

- Reset values:
  - All pulses 0, `btnPressLED` 0.
  - All FSMs IDLE, all counters 0.
  - Synchroniser flops 0.
- Reset asserted mid-debounce or mid-hold aborts everything next edge.
  - A button still held when reset deasserts re-arms from IDLE and produces one pulse after the full debounce.
- Latency:
  - Raw input first sampled high at edge E0 and held.
  - The pulse is high for exactly the cycle following edge E0+D+2: 2 synchroniser edges, then D counted samples ending in acceptance.
  - All outputs are registered.
- Release latency is the same (E0+D+2 to reach IDLE). A new press is accepted only after IDLE is reached.
- A glitch shorter than D samples produces no pulse and no LED.
- `btnPressLED` rises in the same cycle as the pulse and stays high for exactly `LED_HOLD_CYCLES` cycles after the last pulse.

## Structure

- Shared package `lab_pkg`:
  - FSM state enum (IDLE, ARM_HI, PRESSED, ARM_LO).
  - Default debounce/hold constants.
  - Simulation-override constants (D=4, hold=8), used instead of editing the RTL to speed up the clock.
- Sub-module `debounce_channel` (synchroniser + FSM + counter, outputs `press_strobe`), instantiated three times.
- The top level holds the priority arbiter, output registers and LED timer.

## Test plan

All scenarios use D=4, hold=8.

1. Clean press: incrementBtn 0→1 before edge 0, held for 20 cycles → `incrementPulse` high for exactly the one cycle after edge 6. `btnPressLED` high for cycles 6–13. Nothing on release.
2. Bounce rejection: saveBtn toggles 1,0,1,0 every 2 cycles, then stays high → no pulse during bounce. One `savePulse` 6 edges after the final rising sample.
3. Simultaneous: all three buttons rise on the same edge → only `clearPulse` fires. `incrementPulse` and `savePulse` stay 0 throughout.
4. Four increment presses, each held 10 cycles and released 10 cycles → exactly 4 `incrementPulse` strobes. A downstream operand model reads A=4. A subsequent press of `saveBtn` then `incrementBtn` gives B=1, and `resetBtn` gives one `clearPulse`.
5. Retrigger: second press accepted 3 cycles before the LED expires → `btnPressLED` stays continuously high until 8 cycles after the second pulse.
6. Reset mid-debounce: `reset` asserted at edge 3 of a press and released at edge 5 with the button still held → no pulse before reset. One pulse after edge 5+D+2 = 11; all outputs 0 while reset is high.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the button front-end: debounce FSM encoding, timing
// constants and the fixed-priority command arbiter.
package lab_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int LED_HOLD_CYCLES_DEFAULT = 25000000;

  // Shortened timings so a simulation sees whole press/release cycles quickly.
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_LED_HOLD_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } dbn_state_e;

  typedef struct packed {
    logic [1:0] clear_st;
    logic [1:0] save_st;
    logic [1:0] incr_st;
  } dbg_state_t;

  // Bit 2 = clear, bit 1 = save, bit 0 = increment; clear wins over save over increment.
  function automatic logic [2:0] grant_onehot(input logic clr, input logic sav, input logic inc);
    logic [2:0] g;
    g[2] = clr;
    g[1] = sav & ~clr;
    g[0] = inc & ~clr & ~sav;
    return g;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and the conditioned command outputs of the front-end.
interface button_conditioner_if;

  // Handshake: none. Each *Pulse is a single-cycle strobe that downstream must
  // act on in the cycle it is high; there is no ready/backpressure, and at most
  // one strobe is high per cycle. btnPressLED is a plain level.
  logic incrementBtn;
  logic saveBtn;
  logic resetBtn;
  logic incrementPulse;
  logic savePulse;
  logic clearPulse;
  logic btnPressLED;

  modport master (
    output incrementBtn, saveBtn, resetBtn,
    input  incrementPulse, savePulse, clearPulse, btnPressLED
  );

  modport slave (
    input  incrementBtn, saveBtn, resetBtn,
    output incrementPulse, savePulse, clearPulse, btnPressLED
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, then a four-state debounce FSM that
// strobes once when a rising level has been stable for DEBOUNCE_CYCLES samples.
module debounce_channel
  import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    output logic       press_strobe,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] D_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ARM_HI  = ARM_HI;
    localparam logic [1:0] S_PRESSED = PRESSED;
    localparam logic [1:0] S_ARM_LO  = ARM_LO;

    logic          sync1;
    logic          sync2;
    logic [1:0]    state_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state_q <= S_IDLE;
            cnt     <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            case (state_q)
                S_IDLE: begin
                    if (sync2) begin
                        state_q <= S_ARM_HI;
                        cnt     <= ONE;
                    end
                end
                S_ARM_HI: begin
                    if (!sync2) begin
                        state_q <= S_IDLE;
                        cnt     <= '0;
                    end else if (cnt == D_MAX) begin
                        state_q <= S_PRESSED;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_PRESSED: begin
                    if (!sync2) begin
                        state_q <= S_ARM_LO;
                        cnt     <= ONE;
                    end
                end
                S_ARM_LO: begin
                    // A high sample during release is a bounce: stay pressed.
                    if (sync2) begin
                        state_q <= S_PRESSED;
                        cnt     <= '0;
                    end else if (cnt == D_MAX) begin
                        state_q <= S_IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt     <= '0;
                end
            endcase
        end
    end

    // Combinational so the top-level output register lands on the acceptance edge + 1.
    assign press_strobe = (state_q == S_ARM_HI) && sync2 && (cnt == D_MAX);
    assign state        = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front-end: three debounced channels, fixed-priority arbitration into
// registered one-cycle commands, and a retriggerable press-indicator timer.
module button_conditioner
  import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LED_HOLD_CYCLES = LED_HOLD_CYCLES_DEFAULT
) (
    input  logic                  in_clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus,
    output dbg_state_t            dbg_state
);

    localparam int HW = $clog2(LED_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_VAL = HW'(LED_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic       inc_strobe;
    logic       sav_strobe;
    logic       clr_strobe;
    logic [2:0] grant;
    logic       any_grant;

    logic          incr_q;
    logic          save_q;
    logic          clear_q;
    logic          led_q;
    logic [HW-1:0] led_cnt;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_incr (
        .clk          (in_clk),
        .rst          (reset),
        .raw          (bus.incrementBtn),
        .press_strobe (inc_strobe),
        .state        (dbg_state.incr_st)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save (
        .clk          (in_clk),
        .rst          (reset),
        .raw          (bus.saveBtn),
        .press_strobe (sav_strobe),
        .state        (dbg_state.save_st)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk          (in_clk),
        .rst          (reset),
        .raw          (bus.resetBtn),
        .press_strobe (clr_strobe),
        .state        (dbg_state.clear_st)
    );

    assign grant     = grant_onehot(clr_strobe, sav_strobe, inc_strobe);
    assign any_grant = |grant;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            clear_q <= 1'b0;
            save_q  <= 1'b0;
            incr_q  <= 1'b0;
            led_cnt <= '0;
            led_q   <= 1'b0;
        end else begin
            clear_q <= grant[2];
            save_q  <= grant[1];
            incr_q  <= grant[0];
            if (any_grant) begin
                led_cnt <= HOLD_VAL;
            end else if (led_cnt != '0) begin
                led_cnt <= led_cnt - HOLD_ONE;
            end
            // Registered view of (next led_cnt != 0).
            led_q <= any_grant || (led_cnt > HOLD_ONE);
        end
    end

    assign bus.incrementPulse = incr_q;
    assign bus.savePulse      = save_q;
    assign bus.clearPulse     = clear_q;
    assign bus.btnPressLED    = led_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at D=4, hold=8: clean press, bounce,
// simultaneous presses, operand-entry sequence, LED retrigger, reset mid-press.
module tb_button_conditioner
  import lab_pkg::*;
;

  logic       in_clk = 1'b0;
  logic       reset  = 1'b1;
  dbg_state_t dbg_state;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
    .LED_HOLD_CYCLES (SIM_LED_HOLD_CYCLES)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 in_clk = ~in_clk;

  int n_vec = 0;
  int n_err = 0;

  // downstream operand-entry model
  int a_val = 0;
  int b_val = 0;
  bit sel_b = 1'b0;
  int inc_seen = 0;
  int save_seen = 0;
  int clr_seen = 0;

  always @(negedge in_clk) begin
    if (bif.clearPulse) begin
      a_val    <= 0;
      b_val    <= 0;
      sel_b    <= 1'b0;
      clr_seen <= clr_seen + 1;
    end else if (bif.savePulse) begin
      sel_b     <= 1'b1;
      save_seen <= save_seen + 1;
    end else if (bif.incrementPulse) begin
      if (sel_b) b_val <= b_val + 1;
      else       a_val <= a_val + 1;
      inc_seen <= inc_seen + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic inc, input logic sav,
                            input logic clr, input logic led);
    check({tag, "_inc"}, 32'(bif.incrementPulse), 32'(inc));
    check({tag, "_sav"}, 32'(bif.savePulse), 32'(sav));
    check({tag, "_clr"}, 32'(bif.clearPulse), 32'(clr));
    check({tag, "_led"}, 32'(bif.btnPressLED), 32'(led));
  endtask

  task automatic set_btn(input int id, input logic v);
    case (id)
      0:       bif.incrementBtn = v;
      1:       bif.saveBtn = v;
      default: bif.resetBtn = v;
    endcase
  endtask

  task automatic press(input int id, input int hi, input int lo);
    set_btn(id, 1'b1);
    tick(hi);
    set_btn(id, 1'b0);
    tick(lo);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      tick(1);
      expect_out($sformatf("%s_q%0d", tag, j), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check({tag, "_fsm_idle"}, 32'(dbg_state), 32'd0);
  endtask

  int inc_base;
  int save_base;
  int clr_base;

  initial begin
    bif.incrementBtn = 1'b0;
    bif.saveBtn      = 1'b0;
    bif.resetBtn     = 1'b0;

    // reset state
    tick(3);
    expect_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_fsm", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    quiet("post_rst", 3);

    // 1: clean press, pulse after edge 6, LED 6..13, nothing on release
    bif.incrementBtn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      expect_out($sformatf("s1_k%0d", k), k == 6, 1'b0, 1'b0, (k >= 6) && (k <= 13));
    end
    check("s1_pressed", 32'(dbg_state.incr_st), 32'(PRESSED));
    bif.incrementBtn = 1'b0;
    quiet("s1_rel", 12);

    // 2: bounce 1,1,0,0,1,1,0,0 then high; accept 6 edges after edge 8
    for (int k = 0; k < 25; k++) begin
      bif.saveBtn = (k >= 8) ? 1'b1 : (((k / 2) % 2) == 0);
      tick(1);
      expect_out($sformatf("s2_k%0d", k), 1'b0, k == 14, 1'b0, (k >= 14) && (k <= 21));
    end
    bif.saveBtn = 1'b0;
    quiet("s2_rel", 12);

    // 3: all three together, only clear wins
    bif.incrementBtn = 1'b1;
    bif.saveBtn      = 1'b1;
    bif.resetBtn     = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      expect_out($sformatf("s3_k%0d", k), 1'b0, 1'b0, k == 6, (k >= 6) && (k <= 13));
    end
    bif.incrementBtn = 1'b0;
    bif.saveBtn      = 1'b0;
    bif.resetBtn     = 1'b0;
    quiet("s3_rel", 12);
    check("s3_a_cleared", 32'(a_val), 32'd0);

    // 4: operand entry
    inc_base  = inc_seen;
    save_base = save_seen;
    clr_base  = clr_seen;
    for (int p = 0; p < 4; p++) press(0, 10, 10);
    check("s4_inc_count", 32'(inc_seen - inc_base), 32'd4);
    check("s4_a", 32'(a_val), 32'd4);
    press(1, 10, 10);
    press(0, 10, 10);
    check("s4_save_count", 32'(save_seen - save_base), 32'd1);
    check("s4_inc_count2", 32'(inc_seen - inc_base), 32'd5);
    check("s4_a_kept", 32'(a_val), 32'd4);
    check("s4_b", 32'(b_val), 32'd1);
    press(2, 10, 10);
    check("s4_clr_count", 32'(clr_seen - clr_base), 32'd1);
    check("s4_a_clr", 32'(a_val), 32'd0);
    check("s4_b_clr", 32'(b_val), 32'd0);
    quiet("s4_end", 12);

    // 5: second pulse at edge 11 retriggers the LED until edge 18
    bif.incrementBtn = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 5) bif.saveBtn = 1'b1;
      tick(1);
      expect_out($sformatf("s5_k%0d", k), k == 6, k == 11, 1'b0, (k >= 6) && (k <= 18));
    end
    bif.incrementBtn = 1'b0;
    bif.saveBtn      = 1'b0;
    quiet("s5_rel", 12);

    // 6: reset at edges 3-4 mid-debounce, again at edge 14 mid-hold, button held
    bif.incrementBtn = 1'b1;
    for (int k = 0; k < 23; k++) begin
      reset = (k == 3) || (k == 4) || (k == 14);
      tick(1);
      expect_out($sformatf("s6_k%0d", k), (k == 11) || (k == 21), 1'b0, 1'b0,
                 ((k >= 11) && (k <= 13)) || (k >= 21));
      if (reset) check($sformatf("s6_fsm_k%0d", k), 32'(dbg_state), 32'd0);
    end
    reset = 1'b0;
    bif.incrementBtn = 1'b0;
    tick(20);
    expect_out("s6_end", 1'b0, 1'b0, 1'b0, 1'b0);
    check("s6_fsm_idle", 32'(dbg_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
